// File: rtl/seven_segment_scan_driver_if.sv
// Bus between application logic and the 7-segment scan driver.
// The master side (application) supplies display data; the slave side
// (driver) returns status and the pin-level segment/anode signals.
// Optional feature macro: SEVEN_SEGMENT_SCAN_DRIVER_BRIGHTNESS_PWM_EN adds brightness.
interface seven_segment_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    lzb;
`ifdef SEVEN_SEGMENT_SCAN_DRIVER_BRIGHTNESS_PWM_EN
    logic [3:0]              brightness;
`endif
    logic                    update_pending;
    logic                    frame_tick;
    logic [6:0]              seg;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   an;

    modport master (
`ifdef SEVEN_SEGMENT_SCAN_DRIVER_BRIGHTNESS_PWM_EN
        output brightness,
`endif
        output value, dp_in, load, lzb,
        input  update_pending, frame_tick, seg, dp, an
    );

    modport slave (
`ifdef SEVEN_SEGMENT_SCAN_DRIVER_BRIGHTNESS_PWM_EN
        input  brightness,
`endif
        input  value, dp_in, load, lzb,
        output update_pending, frame_tick, seg, dp, an
    );
endinterface

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with hex decode, dead-time
// blanking, frame-aligned double buffering, leading-zero blanking and
// per-digit decimal points. Pins are registered (1 cycle latency).
// Optional feature macro: SEVEN_SEGMENT_SCAN_DRIVER_BRIGHTNESS_PWM_EN
// (4-bit PWM on the anodes during the active part of each slot).
module seven_segment_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 25000,
    parameter int BLANK_CYCLES = 16,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    seven_segment_scan_driver_if.slave   bus
);
    localparam int PRESC_W = $clog2(SCAN_DIV);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [PRESC_W-1:0]    BLANK_END  = PRESC_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    // Pin levels for "off"; XOR with these converts active-high to pin polarity.
    localparam logic [6:0]            SEG_OFF    = {7{ACTIVE_LOW}};
    localparam logic                  DP_OFF     = ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ACTIVE_LOW}};

    logic [PRESC_W-1:0]      presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                    frame_tick_q, frame_tick_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    logic                    slot_end;
    logic                    scan_wrap;
    logic                    anode_en;
    logic [3:0]              nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   zero_from;
    logic [NUM_DIGITS-1:0]   blank_vec;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
            4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
            4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
            4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign slot_end  = (presc_q == PRESC_LAST);
    assign scan_wrap = slot_end && (idx_q == IDX_LAST);

    // Per-digit nibble view and leading-zero blank decision; digit 0 always shows.
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign nib[gi] = disp_val_q[4*gi +: 4];
        if (gi == 0) begin : g_lsd
            assign blank_vec[gi] = 1'b0;
        end else begin : g_upper
            assign blank_vec[gi] = bus.lzb && zero_from[gi] && !disp_dp_q[gi];
        end
    end

    // zero_from[i]: digit i and every digit above it are zero.
    always_comb begin
        logic acc;
        acc       = 1'b1;
        zero_from = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc          = acc && (nib[i] == 4'h0);
            zero_from[i] = acc;
        end
    end

`ifdef SEVEN_SEGMENT_SCAN_DRIVER_BRIGHTNESS_PWM_EN
    logic [3:0] pwm_cnt_q;

    // Free-running PWM phase counter for anode dimming.
    always_ff @(posedge clk) begin
        if (!rst_n) pwm_cnt_q <= 4'h0;
        else        pwm_cnt_q <= pwm_cnt_q + 4'h1;
    end

    assign anode_en = (pwm_cnt_q <= bus.brightness);
`else
    assign anode_en = 1'b1;
`endif

    // Prescaler/index advance and frame-aligned transfer of pending data.
    always_comb begin
        presc_d      = slot_end ? '0 : presc_q + 1'b1;
        idx_d        = idx_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pending_d    = pending_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        frame_tick_d = scan_wrap;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        if (scan_wrap) begin
            // A load on the wrap edge bypasses the pending buffer.
            if (bus.load) begin
                disp_val_d = bus.value;
                disp_dp_d  = bus.dp_in;
            end else if (pending_q) begin
                disp_val_d = pend_val_q;
                disp_dp_d  = pend_dp_q;
            end
            pending_d = 1'b0;
        end else if (bus.load) begin
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp_in;
            pending_d  = 1'b1;
        end
    end

    // Pin values for the current slot; all-off during the dead-time window.
    always_comb begin
        logic [6:0]            seg_hi;
        logic                  dp_hi;
        logic [NUM_DIGITS-1:0] an_hi;
        seg_hi = 7'h00;
        dp_hi  = 1'b0;
        an_hi  = '0;
        if (presc_q >= BLANK_END) begin
            if (!blank_vec[idx_q]) begin
                seg_hi = glyph(nib[idx_q]);
                dp_hi  = disp_dp_q[idx_q];
            end
            if (anode_en) begin
                an_hi = NUM_DIGITS'(1) << idx_q;
            end
        end
        seg_d = seg_hi ^ SEG_OFF;
        dp_d  = dp_hi ^ DP_OFF;
        an_d  = an_hi ^ AN_OFF;
    end

    // State and output registers; reset drops everything, including pending data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pending_q    <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            frame_tick_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pending_q    <= pending_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            frame_tick_q <= frame_tick_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign bus.update_pending = pending_q;
    assign bus.frame_tick     = frame_tick_q;
    assign bus.seg            = seg_q;
    assign bus.dp             = dp_q;
    assign bus.an             = an_q;
endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver (4 digits, SCAN_DIV=8, 2 blank cycles,
// common-anode). A cycle-level reference derives the expected pins from the
// number of clock edges since reset release; a negedge process compares every
// cycle, and directed points pin the reference against hand-computed values.
module tb_seven_segment_scan_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seven_segment_scan_driver_if #(.NUM_DIGITS(4)) bus();

    seven_segment_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference state: edges since release, displayed and pending buffers.
    int          k = 0;
    logic [15:0] m_disp = '0, m_pend = '0;
    logic [3:0]  m_ddp = '0, m_pdp = '0;
    logic        m_pending = 1'b0;
    logic [11:0] e_pins = {4'hF, 1'b1, 7'h7F};   // {an, dp, seg}
    logic        e_ft = 1'b0, e_up = 1'b0, e_valid = 1'b0;

    // Pins after edge kk: they show the slot state that held before that edge.
    function automatic logic [11:0] model_pins(input logic [15:0] disp, input logic [3:0] ddp,
                                               input logic lz, input int kk);
        int q, p, d;
        logic [3:0] nibv;
        logic blank;
        q = kk - 1;
        p = q % 8;
        d = (q / 8) % 4;
        if (p < 2) return {4'hF, 1'b1, 7'h7F};
        nibv  = 4'((disp >> (4 * d)) & 16'hF);
        blank = lz && (d != 0) && ((disp >> (4 * d)) == 16'h0) && !ddp[d];
        return {~(4'b0001 << d), blank ? 1'b1 : ~ddp[d], blank ? 7'h7F : ~glyph_tab[nibv]};
    endfunction

    always @(posedge clk) begin
        e_valid <= 1'b1;
        if (!rst_n) begin
            k <= 0; m_disp <= '0; m_ddp <= '0; m_pend <= '0; m_pdp <= '0; m_pending <= 1'b0;
            e_pins <= {4'hF, 1'b1, 7'h7F}; e_ft <= 1'b0; e_up <= 1'b0;
        end else begin
            k      <= k + 1;
            e_pins <= model_pins(m_disp, m_ddp, bus.lzb, k + 1);
            e_ft   <= ((k + 1) % 32 == 0);
            if ((k + 1) % 32 == 0) begin
                if (bus.load) begin
                    m_disp <= bus.value; m_ddp <= bus.dp_in;
                end else if (m_pending) begin
                    m_disp <= m_pend; m_ddp <= m_pdp;
                end
                m_pending <= 1'b0; e_up <= 1'b0;
            end else if (bus.load) begin
                m_pend <= bus.value; m_pdp <= bus.dp_in; m_pending <= 1'b1; e_up <= 1'b1;
            end else begin
                e_up <= m_pending;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d actual=%0h required=%0h", name, k, act, exp);
        end
    endtask

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        if (e_valid) begin
            check("an",   32'(bus.an),             32'(e_pins[11:8]));
            check("dp",   32'(bus.dp),             32'(e_pins[7]));
            check("seg",  32'(bus.seg),            32'(e_pins[6:0]));
            check("tick", 32'(bus.frame_tick),     32'(e_ft));
            check("pend", 32'(bus.update_pending), 32'(e_up));
        end
    end

    task automatic goto(input int target);
        int n;
        n = 0;
        while (k != target) begin
            @(negedge clk);
            n++;
            if (n > 4000) begin
                checks++;
                failures++;
                $display("FAIL goto_timeout actual=%0d required=%0d", k, target);
                return;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        bus.value = v; bus.dp_in = d; bus.load = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.value = '0; bus.dp_in = '0; bus.load = 1'b0; bus.lzb = 1'b0;
`ifdef SEVEN_SEGMENT_SCAN_DRIVER_BRIGHTNESS_PWM_EN
        bus.brightness = 4'hF;
`endif
        repeat (3) @(negedge clk);
        check("rst_an",   32'(bus.an), 32'h0F);
        check("rst_seg",  32'(bus.seg), 32'h7F);
        check("rst_dp",   32'(bus.dp), 32'h1);
        check("rst_pend", 32'(bus.update_pending), 32'h0);
        rst_n = 1'b1;

        // Release: two blank cycles plus one cycle of latency.
        goto(2);  check("t1_an2", 32'(bus.an), 32'h0F);
        goto(3);  check("t1_an3", 32'(bus.an), 32'h0E);
                  check("t1_seg3", 32'(bus.seg), 32'h40);
        goto(31); check("t1_ft31", 32'(bus.frame_tick), 32'h0);
        goto(32); check("t1_ft32", 32'(bus.frame_tick), 32'h1);
        goto(33); check("t1_ft33", 32'(bus.frame_tick), 32'h0);

        // Mid-frame load, shown from the next frame.
        goto(40); do_load(16'h12AF, 4'b0100);
        goto(41); bus.load = 1'b0; check("t2_pend", 32'(bus.update_pending), 32'h1);
        goto(64); check("t2_pend_clr", 32'(bus.update_pending), 32'h0);
        goto(67); check("t2_d0", 32'({bus.an, bus.dp, bus.seg}), 32'({4'b1110, 1'b1, 7'h0E}));
        goto(75); check("t2_d1", 32'({bus.an, bus.dp, bus.seg}), 32'({4'b1101, 1'b1, 7'h08}));
        goto(83); check("t2_d2", 32'({bus.an, bus.dp, bus.seg}), 32'({4'b1011, 1'b0, 7'h24}));
        goto(91); check("t2_d3", 32'({bus.an, bus.dp, bus.seg}), 32'({4'b0111, 1'b1, 7'h79}));

        // Two loads in one frame: last one wins.
        goto(100); do_load(16'h1111, 4'h0);
        goto(101); bus.load = 1'b0;
        goto(110); do_load(16'h2222, 4'h0);
        goto(111); bus.load = 1'b0;
        goto(131); check("t3_d0", 32'(bus.seg), 32'h24);
        goto(139); check("t3_d1", 32'(bus.seg), 32'h24);
        goto(147); check("t3_d2", 32'(bus.seg), 32'h24);
        goto(155); check("t3_d3", 32'(bus.seg), 32'h24);

        // Load exactly on the wrap edge goes straight to the display.
        goto(191); do_load(16'h3456, 4'h0);
        goto(192); bus.load = 1'b0; check("t4_pend", 32'(bus.update_pending), 32'h0);
        goto(195); check("t4_d0", 32'({bus.an, bus.seg}), 32'({4'b1110, 7'h02}));

        // Leading-zero blanking.
        goto(200); bus.lzb = 1'b1; do_load(16'h0040, 4'h0);
        goto(201); bus.load = 1'b0;
        goto(227); check("t5_d0", 32'({bus.an, bus.dp, bus.seg}), 32'({4'b1110, 1'b1, 7'h40}));
        goto(235); check("t5_d1", 32'({bus.an, bus.dp, bus.seg}), 32'({4'b1101, 1'b1, 7'h19}));
        goto(243); check("t5_d2", 32'({bus.an, bus.dp, bus.seg}), 32'({4'b1011, 1'b1, 7'h7F}));
        goto(251); check("t5_d3", 32'({bus.an, bus.dp, bus.seg}), 32'({4'b0111, 1'b1, 7'h7F}));
        goto(260); do_load(16'h0000, 4'h0);
        goto(261); bus.load = 1'b0;
        goto(291); check("t5_z0", 32'({bus.an, bus.seg}), 32'({4'b1110, 7'h40}));
        goto(299); check("t5_z1", 32'({bus.an, bus.seg}), 32'({4'b1101, 7'h7F}));

        // Randomised traffic, checked every cycle by the reference.
        goto(300);
        for (int t = 300; t < 900; t++) begin
            goto(t);
            bus.value = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            bus.dp_in = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            bus.lzb   = 1'($urandom);
            bus.load  = ($urandom_range(0, 5) == 0);
        end

        // Reset mid-slot drops a pending update and clears the display.
        goto(900); bus.lzb = 1'b0; do_load(16'hF00D, 4'h0);
        goto(901); bus.load = 1'b0;
        goto(903); check("t6_pend_pre", 32'(bus.update_pending), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_pins", 32'({bus.an, bus.dp, bus.seg}), 32'({4'hF, 1'b1, 7'h7F}));
        check("t6_rst_pend", 32'(bus.update_pending), 32'h0);
        rst_n = 1'b1;
        goto(3);  check("t6_d0", 32'({bus.an, bus.seg}), 32'({4'b1110, 7'h40}));
        goto(11); check("t6_d1", 32'({bus.an, bus.seg}), 32'({4'b1101, 7'h40}));
        goto(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
